// File: rtl/nibble_serial_adder_ctrl_if.sv
// Requester <-> serial adder bus.
//   master : requester side, drives start/a/b/cin, observes busy/done/s/cout/ovf
//   slave  : adder side, the reverse
// Signals: start (request), a/b (W-bit operands), cin (carry-in),
//          busy (add in progress), done (1-cycle completion pulse),
//          s (W-bit sum), cout (MSB carry-out), ovf (signed overflow).
interface nibble_serial_adder_ctrl_if #(
  parameter int NIB = 4
);
  localparam int W = 4 * NIB;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder built from one shared 4-bit slice. Operands are latched on an
// accepted start, then one nibble is added per cycle, LSB first, with the
// carry chained through a register. The finished sum, carry-out and signed
// overflow are published together with a one-cycle done pulse and held until
// the next completion.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, abandons any in-flight add
//   bus  - slave side of nibble_serial_adder_ctrl_if (start/a/b/cin in,
//          busy/done/s/cout/ovf out)
module nibble_serial_adder_ctrl #(
  parameter int NIB = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  nibble_serial_adder_ctrl_if.slave  bus
);
  localparam int W  = 4 * NIB;
  localparam int KW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          carry_q, carry_d;
  logic [KW-1:0] k_q, k_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  s_q, s_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  // Shared nibble slice
  logic [3:0]    a_nib, b_nib;
  logic [3:0]    low_sum;   // bits 2:0 of the nibble plus carry into bit 3
  logic          c_bit3;
  logic [3:0]    nib_sum;
  logic          nib_cout;
  logic          last_nib;

  // Operand nibble select
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (k_q == KW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  // Slice split at bit 3 so the carry into the top bit is visible; on the
  // MSB nibble that carry is the one the overflow flag needs.
  always_comb begin
    low_sum  = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_q};
    c_bit3   = low_sum[3];
    nib_sum  = {a_nib[3] ^ b_nib[3] ^ c_bit3, low_sum[2:0]};
    nib_cout = (a_nib[3] & b_nib[3]) | (c_bit3 & (a_nib[3] ^ b_nib[3]));
    last_nib = (k_q == KW'(NIB - 1));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    k_d     = k_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      RUN: begin
        for (int unsigned i = 0; i < NIB; i++) begin
          if (k_q == KW'(i)) begin
            acc_d[4*i +: 4] = nib_sum;
          end
        end
        carry_d = nib_cout;
        if (last_nib) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          k_d     = '0;
          s_d     = acc_d;
          cout_d  = nib_cout;
          ovf_d   = c_bit3 ^ nib_cout;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      default: begin  // IDLE and DONE accept a new request identically
        state_d = IDLE;
        busy_d  = 1'b0;
        if (bus.start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          acc_d   = '0;
          k_d     = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
